// File: rtl/fb_scanout_pkg.sv
// Shared framebuffer geometry for the draw unit and fb_scanout.
// SCANOUT_DOUBLE_EN selects 2x pixel/line doubling (128 x 64 output).
package fb_scanout_pkg;

  localparam int FB_WIDTH         = 64;
  localparam int FB_HEIGHT        = 32;
  localparam int FB_BYTES_PER_ROW = 8;
  localparam int FB_BYTES         = 256;
  localparam logic [15:0] SCREEN_START_DEFAULT = 16'h0100;
  localparam int MEM_LATENCY      = 1;

`ifdef SCANOUT_DOUBLE_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  localparam int OUT_W       = FB_WIDTH * SCALE;
  localparam int OUT_H       = FB_HEIGHT * SCALE;
  localparam int CUR_W       = 8 * SCALE;
  localparam int CNT_W       = $clog2(CUR_W + 1);
  localparam int FETCH_TOTAL = FB_BYTES * SCALE;
  localparam int FETCH_W     = $clog2(FETCH_TOTAL + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Repeats every source bit SCALE times so the shifter emits doubled pixels.
  function automatic logic [CUR_W-1:0] expand_byte(input logic [7:0] b);
    logic [CUR_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < SCALE; j++) begin
        r[i*SCALE + j] = b[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_pixel_shifter.sv
// Current/prefetch byte buffer that serialises framebuffer bytes MSB first
// with a valid/ready handshake (doubled bits when SCANOUT_DOUBLE_EN is set).
module fb_pixel_shifter
  import fb_scanout_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_ready,
  output logic       o_valid,
  output logic       o_pixel,
  output logic       o_nxt_vld
);

  logic [CUR_W-1:0] r_cur;
  logic [CUR_W-1:0] r_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_nxt_vld;

  logic [CUR_W-1:0] w_load;
  logic [CUR_W-1:0] w_cur_sh;
  logic [CNT_W-1:0] w_cnt_sh;
  logic             w_accept;
  logic             w_cur_empty;

  assign w_load      = expand_byte(i_byte);
  assign w_accept    = (r_cnt != '0) && i_ready;
  assign w_cnt_sh    = r_cnt - CNT_W'(w_accept);
  assign w_cur_sh    = w_accept ? (r_cur << 1) : r_cur;
  assign w_cur_empty = (w_cnt_sh == '0);

  assign o_valid   = (r_cnt != '0);
  assign o_pixel   = r_cur[CUR_W-1];
  assign o_nxt_vld = r_nxt_vld;

  // "Empty" is judged after this cycle's shift so a refill never costs a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur     <= '0;
      r_nxt     <= '0;
      r_cnt     <= '0;
      r_nxt_vld <= 1'b0;
    end else begin
      r_cur <= w_cur_sh;
      r_cnt <= w_cnt_sh;
      if (w_cur_empty && r_nxt_vld) begin
        r_cur     <= r_nxt;
        r_cnt     <= CNT_W'(CUR_W);
        r_nxt_vld <= i_load;
        if (i_load) r_nxt <= w_load;
      end else if (w_cur_empty && i_load) begin
        r_cur <= w_load;
        r_cnt <= CNT_W'(CUR_W);
      end else if (i_load) begin
        r_nxt     <= w_load;
        r_nxt_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: fetches bytes from the shared memory port and streams
// raster pixels. SCANOUT_DOUBLE_EN enables 128 x 64 doubled output.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter logic [15:0] SCREEN_START = SCREEN_START_DEFAULT
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  input  logic        mem_busy,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_read_byte,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        pixel,
  output logic [6:0]  pixel_x,
  output logic [5:0]  pixel_y
);

  state_t r_state;
  state_t w_state_next;

  logic [FETCH_W-1:0]     r_fetch;
  logic [MEM_LATENCY-1:0] r_rd_pipe;
  logic [6:0]             r_x;
  logic [5:0]             r_y;

  logic        w_scan;
  logic        w_fetch_left;
  logic        w_mem_read;
  logic        w_pix_valid;
  logic        w_nxt_vld;
  logic        w_accept;
  logic        w_last_pix;
  logic [15:0] w_byte_idx;

  assign w_fetch_left = (r_fetch < FETCH_W'(FETCH_TOTAL));
  assign w_accept     = w_pix_valid && pixel_ready;
  assign w_last_pix   = (r_x == 7'(OUT_W - 1)) && (r_y == 6'(OUT_H - 1));

`ifdef SCANOUT_DOUBLE_EN
  // Fetch bit 3 selects the first or repeated pass over a source row.
  assign w_byte_idx = 16'({r_fetch[FETCH_W-1:4], r_fetch[2:0]});
`else
  assign w_byte_idx = 16'(r_fetch);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_SCAN;
      ST_SCAN: if (w_accept && w_last_pix) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_scan     = (r_state == ST_SCAN);
    busy       = w_scan;
    frame_done = (r_state == ST_DONE);
  end

  assign w_mem_read = w_scan && !(|r_rd_pipe) && !w_nxt_vld && w_fetch_left && !mem_busy;
  assign mem_read   = w_mem_read;
  assign mem_addr   = w_mem_read ? (SCREEN_START + w_byte_idx) : 16'h0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pipe <= '0;
      r_fetch   <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_rd_pipe <= (r_rd_pipe << 1) | MEM_LATENCY'(w_mem_read);
      if (r_state == ST_IDLE && start) begin
        r_fetch <= '0;
        r_x     <= '0;
        r_y     <= '0;
      end else begin
        if (w_mem_read) r_fetch <= r_fetch + FETCH_W'(1);
        if (w_accept) begin
          if (r_x == 7'(OUT_W - 1)) begin
            r_x <= '0;
            r_y <= (r_y == 6'(OUT_H - 1)) ? 6'd0 : r_y + 6'd1;
          end else begin
            r_x <= r_x + 7'd1;
          end
        end
      end
    end
  end

  fb_pixel_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .i_load    (r_rd_pipe[MEM_LATENCY-1]),
    .i_byte    (mem_read_byte),
    .i_ready   (pixel_ready),
    .o_valid   (w_pix_valid),
    .o_pixel   (pixel),
    .o_nxt_vld (w_nxt_vld)
  );

  assign pixel_valid = w_pix_valid;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;

endmodule
